// File: rtl/adder_ins_packer.sv
// -----------------------------------------------------------------------------
// adder_ins_packer
//
// Upstream feeder for the adder stage. Collects a byte-serial stream into the
// 65-bit packed ins bus {s2.w, s2.z, s2.y, s2.x, cin, s1.w, s1.z, s1.y, s1.x}.
// Bytes 0..6 of a frame are staged in a shadow register so that ins only
// changes, all at once, on the edge that accepts byte 7. ins is then held
// stable until the next frame completes.
//
// Parameters
//   DRAIN_CYC  cycles byte_rdy stays low after a frame completes (0..15)
//   CNT_W      width of frame_cnt
//
// Ports
//   clk        clock, all flops on the rising edge
//   rst_n      asynchronous active-low reset
//   byte_vld   upstream byte valid
//   byte_data  upstream byte
//   byte_cin   carry-in, sampled only with byte index 0
//   byte_rdy   packer can accept a byte this cycle (combinational)
//   abort      synchronous discard of the partial frame / early end of hold
//   ins        packed frame to the adder
//   ins_vld    1-cycle pulse: ins was updated by the previous edge
//   res_vld    1-cycle pulse: adder registered outputs reflect this frame
//   frame_cnt  frames published, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module adder_ins_packer #(
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_vld,
  input  logic [7:0]       byte_data,
  input  logic             byte_cin,
  output logic             byte_rdy,
  input  logic             abort,
  output logic [64:0]      ins,
  output logic             ins_vld,
  output logic             res_vld,
  output logic [CNT_W-1:0] frame_cnt
);

  // One adder operand: four byte lanes, x in the least significant byte.
  typedef struct packed {
    logic [7:0] w;
    logic [7:0] z;
    logic [7:0] y;
    logic [7:0] x;
  } operand_t;

  // Packed frame layout; declaration order gives s2 at [64:33], cin at [32]
  // and s1 at [31:0].
  typedef struct packed {
    operand_t s2;
    logic     cin;
    operand_t s1;
  } frame_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // The hold counter is loaded on the edge that accepts byte 7 and counts
  // down to zero; the cycle in which it reads zero is the last hold cycle.
  localparam logic [3:0] HOLD_INIT = (DRAIN_CYC == 0) ? 4'd0 : 4'(DRAIN_CYC - 1);

  state_t          state;
  logic [2:0]      idx;
  logic [3:0]      hold_cnt;
  logic [6:0][7:0] shadow;
  logic            shadow_cin;
  logic            accept;
  logic            last_byte;
  frame_t          next_frame;

  // rst_n is folded in so that every output reads 0 while reset is held;
  // in the first cycle after release the FSM is in COLLECT and byte_rdy=1.
  assign byte_rdy  = rst_n & (state == COLLECT) & ~abort;
  assign accept    = byte_vld & byte_rdy;
  assign last_byte = accept & (idx == 3'd7);

  // ---------------------------------------------------------------------------
  // Shadow staging for bytes 0..6.
  // NOTE: the shadow is a data store qualified entirely by idx, so it carries
  // no reset; after reset or abort idx restarts at 0 and every lane is
  // rewritten before it can reach ins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      if (accept && (idx == 3'(i))) begin
        shadow[i] <= byte_data;
      end
    end
    if (accept && (idx == 3'd0)) begin
      shadow_cin <= byte_cin;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame image presented to ins when byte 7 arrives: bytes 0..6 from the
  // shadow, byte 7 straight from the input bus.
  // NOTE: every field gets a default first so no path through this block can
  // leave a bit unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_frame      = '0;
    next_frame.s1.x = shadow[0];
    next_frame.s1.y = shadow[1];
    next_frame.s1.z = shadow[2];
    next_frame.s1.w = shadow[3];
    next_frame.cin  = shadow_cin;
    next_frame.s2.x = shadow[4];
    next_frame.s2.y = shadow[5];
    next_frame.s2.z = shadow[6];
    next_frame.s2.w = byte_data;
  end

  // ---------------------------------------------------------------------------
  // Control FSM, output register and frame counter.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= 3'd0;
      hold_cnt  <= 4'd0;
      ins       <= '0;
      ins_vld   <= 1'b0;
      res_vld   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // The pulse pipeline is never touched by abort: once byte 7 has been
      // accepted, ins_vld and then res_vld follow on the next two cycles.
      ins_vld <= last_byte;
      res_vld <= ins_vld;

      if (last_byte) begin
        ins       <= next_frame;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end

      case (state)
        COLLECT: begin
          if (abort) begin
            // byte_rdy is low this cycle, so no byte is taken; restart the frame.
            idx <= 3'd0;
          end else if (accept) begin
            if (idx == 3'd7) begin
              idx <= 3'd0;
              if (DRAIN_CYC != 0) begin
                state    <= HOLD;
                hold_cnt <= HOLD_INIT;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        HOLD: begin
          if (abort || (hold_cnt == 4'd0)) begin
            state <= COLLECT;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_ins_packer.sv
// -----------------------------------------------------------------------------
// tb_adder_ins_packer
//
// Directed bench for adder_ins_packer. Two instances share all stimulus: the
// default configuration (DRAIN_CYC=2, CNT_W=16) and a narrow-counter one
// (CNT_W=2) used to observe frame_cnt wrap. Expected frames are built from
// the field map, pushed to a scoreboard when byte 7 is accepted and popped
// when ins_vld is observed.
// -----------------------------------------------------------------------------
module tb_adder_ins_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_vld;
  logic [7:0]  byte_data;
  logic        byte_cin;
  logic        abort;

  logic        byte_rdy;
  logic [64:0] ins;
  logic        ins_vld;
  logic        res_vld;
  logic [15:0] frame_cnt;

  logic        sm_byte_rdy;
  logic [64:0] sm_ins;
  logic        sm_ins_vld;
  logic        sm_res_vld;
  logic [1:0]  sm_frame_cnt;

  always #5 clk = ~clk;

  adder_ins_packer #(.DRAIN_CYC(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_cin  (byte_cin),
    .byte_rdy  (byte_rdy),
    .abort     (abort),
    .ins       (ins),
    .ins_vld   (ins_vld),
    .res_vld   (res_vld),
    .frame_cnt (frame_cnt)
  );

  adder_ins_packer #(.DRAIN_CYC(2), .CNT_W(2)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_cin  (byte_cin),
    .byte_rdy  (sm_byte_rdy),
    .abort     (abort),
    .ins       (sm_ins),
    .ins_vld   (sm_ins_vld),
    .res_vld   (sm_res_vld),
    .frame_cnt (sm_frame_cnt)
  );

  typedef struct {
    logic [64:0] frame;
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          res_q[$];
  int          vld_cyc_q[$];
  exp_t        mon_e;
  int          mon_r;
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          vld_count = 0;
  logic [15:0] model_cnt = '0;
  logic [64:0] last_frame = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing straight from the field map.
  function automatic logic [64:0] pack(input logic [63:0] b, input logic c);
    logic [64:0] f;
    f = '0;
    for (int i = 0; i < 4; i++) f[8*i +: 8] = b[8*i +: 8];
    f[32] = c;
    for (int i = 4; i < 8; i++) f[33 + 8*(i-4) +: 8] = b[8*i +: 8];
    return f;
  endfunction

  // Offer one byte after 'gap' idle cycles; returns at posedge+1 of the
  // accepting edge, with the number of cycles byte_rdy was low.
  task automatic send_byte(input logic [7:0] d, input logic c, input int gap,
                           output int stalls);
    logic rdy_s;
    stalls   = 0;
    rdy_s    = 1'b0;
    byte_vld = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_vld  = 1'b1;
    byte_data = d;
    byte_cin  = c;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      rdy_s = byte_rdy;
      @(posedge clk);
      #1;
      if (rdy_s) begin
        byte_vld = 1'b0;
        return;
      end
      stalls++;
    end
    byte_vld = 1'b0;
    check("byte_accept_timeout", rdy_s, 1'b1);
  endtask

  // Send bytes 0..7 (byte i = b[8i+:8]); byte_cin carries c only at idx 0
  // and its complement elsewhere, which the packer must ignore.
  task automatic send_frame(input logic [63:0] b, input logic c, input int max_gap,
                            output int first_stall);
    int st;
    int g;
    first_stall = 0;
    for (int i = 0; i < 8; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      send_byte(b[8*i +: 8], (i == 0) ? c : ~c, g, st);
      if (i == 0) first_stall = st;
    end
    model_cnt++;
    last_frame = pack(b, c);
    sb_q.push_back('{frame: last_frame, cyc: cyc, cnt: model_cnt});
  endtask

  // Output monitor: scoreboard pop on ins_vld, cycle check on res_vld.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ins_vld) begin
        vld_count++;
        vld_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("ins_vld_unexpected", ins_vld, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("ins", ins, mon_e.frame);
          check("ins_vld_cycle", cyc, mon_e.cyc);
          check("frame_cnt", frame_cnt, mon_e.cnt);
          check("small_ins_vld", sm_ins_vld, 1'b1);
          check("small_ins", sm_ins, mon_e.frame);
          check("small_frame_cnt", sm_frame_cnt, mon_e.cnt[1:0]);
          res_q.push_back(mon_e.cyc + 1);
        end
      end
      if (res_vld) begin
        if (res_q.size() == 0) begin
          check("res_vld_unexpected", res_vld, 1'b0);
        end else begin
          mon_r = res_q.pop_front();
          check("res_vld_cycle", cyc, mon_r);
          check("small_res_vld", sm_res_vld, 1'b1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int vc0;
    int n;

    rst_n     = 1'b0;
    byte_vld  = 1'b0;
    byte_data = 8'h00;
    byte_cin  = 1'b0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, first cycle after release.
    @(negedge clk);
    check("rst_ins", ins, 65'h0);
    check("rst_ins_vld", ins_vld, 1'b0);
    check("rst_res_vld", res_vld, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'h0);
    check("rst_byte_rdy", byte_rdy, 1'b1);
    check("rst_small_byte_rdy", sm_byte_rdy, 1'b1);
    @(posedge clk);
    #1;

    // Test 1: back-to-back 01..08, cin=1.
    send_frame(64'h08070605_04030201, 1'b1, 0, st);
    @(negedge clk);
    check("t1_ins_literal", ins, 65'h0_100E0C0B_04030201);
    check("t1_ins_vld_t1", ins_vld, 1'b1);
    check("t1_res_vld_t1", res_vld, 1'b0);
    @(negedge clk);
    check("t1_ins_vld_t2", ins_vld, 1'b0);
    check("t1_res_vld_t2", res_vld, 1'b1);
    @(negedge clk);
    check("t1_res_vld_t3", res_vld, 1'b0);
    @(posedge clk);
    #1;

    // Test 2: same frame with random bubbles.
    vc0 = vld_count;
    send_frame(64'h08070605_04030201, 1'b1, 2, st);
    repeat (4) @(negedge clk);
    check("t2_one_ins_vld", vld_count - vc0, 1);
    check("t2_ins_literal", ins, 65'h0_100E0C0B_04030201);
    @(posedge clk);
    #1;

    // Test 3: three AA bytes, abort, then eight FF bytes with cin=0.
    for (int i = 0; i < 3; i++) send_byte(8'hAA, 1'b1, 0, st);
    check("t3_ins_stable_collect", ins, last_frame);
    abort     = 1'b1;
    byte_vld  = 1'b1;
    byte_data = 8'hAA;
    @(negedge clk);
    check("t3_abort_rdy_low", byte_rdy, 1'b0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    byte_vld = 1'b0;
    send_frame(64'hFFFFFFFF_FFFFFFFF, 1'b0, 0, st);
    // Abort during HOLD: back in COLLECT one cycle earlier than the drain.
    abort = 1'b1;
    @(negedge clk);
    check("t3_hold_rdy_low", byte_rdy, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t3_hold_abort_exit", byte_rdy, 1'b1);
    check("t3_ins_literal", ins, 65'h1_FFFFFFFE_FFFFFFFF);
    @(posedge clk);
    #1;

    // Test 4: three frames with byte_vld held high.
    for (int f = 0; f < 3; f++) begin
      send_frame({8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'(f)}, f[0], 0, st);
      if (f > 0) check("t4_drain_stall", st, 2);
    end
    @(negedge clk);
    check("t4_rdy_t1", byte_rdy, 1'b0);
    @(negedge clk);
    check("t4_rdy_t2", byte_rdy, 1'b0);
    @(negedge clk);
    check("t4_rdy_t3", byte_rdy, 1'b1);
    n = vld_cyc_q.size();
    check("t4_period_a", vld_cyc_q[n-2] - vld_cyc_q[n-3], 10);
    check("t4_period_b", vld_cyc_q[n-1] - vld_cyc_q[n-2], 10);
    repeat (2) @(posedge clk);
    #1;

    // Test 6: reset after five bytes, then a clean frame.
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b1, 0, st);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ins", ins, 65'h0);
    check("t6_rst_ins_vld", ins_vld, 1'b0);
    check("t6_rst_res_vld", res_vld, 1'b0);
    check("t6_rst_frame_cnt", frame_cnt, 16'h0);
    check("t6_rst_byte_rdy", byte_rdy, 1'b0);
    check("t6_rst_small_cnt", sm_frame_cnt, 2'h0);
    sb_q.delete();
    res_q.delete();
    model_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rdy_after_release", byte_rdy, 1'b1);
    @(posedge clk);
    #1;
    send_frame(64'h08070605_04030201, 1'b1, 0, st);
    @(negedge clk);
    check("t6_ins_literal", ins, 65'h0_100E0C0B_04030201);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    check("res_drained", res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
